// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Fetch-side program-counter sequencer. It advances the PC
//            sequentially, holds it on stall, and redirects on a branch or
//            jump with one architectural delay slot. Redirect targets are
//            range-checked. Reaching PC_LIMIT halts, and an illegal redirect
//            faults. Both of those terminal states stay set until reset.
// Ports    : clk, rst (sync, active-high)
//            stall                          - hold PC, no issue this cycle
//            br_valid/br_taken/br_target    - conditional branch at pc
//            jmp_valid/jmp_target           - unconditional jump at pc
//            pc, pc_valid, in_delay_slot    - fetch address and qualifiers
//            halted, fault                  - sticky terminal status
//            issue_count                    - issued instructions (mod 2^32)
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] PC_LIMIT = 32'h0000_7000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp_valid,
  input  logic [31:0] jmp_target,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        in_delay_slot,
  output logic        halted,
  output logic        fault,
  output logic [31:0] issue_count
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SLOT  = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] target_q, target_d;
  logic [31:0] issue_count_q, issue_count_d;

  logic        issue;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        target_legal;
  logic [31:0] pc_plus4;

  // Request decode. A jump takes priority over a branch.
  always_comb begin
    issue           = ((state_q == ST_RUN) || (state_q == ST_SLOT)) && !stall;
    redirect        = jmp_valid || (br_valid && br_taken);
    redirect_target = jmp_valid ? jmp_target : br_target;
    // PC_LIMIT itself is a legal target. Landing on it is a normal halt.
    target_legal    = (redirect_target[1:0] == 2'b00) &&
                      (redirect_target >= RESET_PC) &&
                      (redirect_target <= PC_LIMIT);
    pc_plus4        = pc_q + 32'd4;
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    target_d      = target_q;
    issue_count_d = issue_count_q;

    if (issue) begin
      issue_count_d = issue_count_q + 32'd1;
      case (state_q)
        ST_RUN: begin
          if (redirect) begin
            if (target_legal) begin
              target_d = redirect_target;
              pc_d     = pc_plus4;        // fetch the delay slot first
              state_d  = ST_SLOT;
            end else begin
              state_d  = ST_FAULT;        // pc holds, nothing latched
            end
          end else begin
            pc_d = pc_plus4;
          end
        end
        ST_SLOT: begin
          // A redirect that sits in a delay slot is architecturally illegal.
          if (redirect) begin
            state_d = ST_FAULT;
          end else begin
            pc_d    = target_q;
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase

      // Any path whose next fetch would land on PC_LIMIT halts in the same
      // update. This also overrides entering the delay slot.
      if ((state_d != ST_FAULT) && (pc_d == PC_LIMIT)) begin
        state_d = ST_HALT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      target_q      <= 32'd0;
      issue_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      target_q      <= target_d;
      issue_count_q <= issue_count_d;
    end
  end

  // All outputs come straight from registered state.
  always_comb begin
    pc            = pc_q;
    issue_count   = issue_count_q;
    pc_valid      = (state_q == ST_RUN) || (state_q == ST_SLOT);
    in_delay_slot = (state_q == ST_SLOT);
    halted        = (state_q == ST_HALT);
    fault         = (state_q == ST_FAULT);
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Self-checking bench for pc_sequencer. A driver issues directed
//            and random cycles and pushes the expected outputs of a
//            behavioural model into a queue. A monitor pops each entry and
//            compares it against the DUT one step after the clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] LIMIT  = 32'h0000_7000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        br_valid = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'd0;
  logic        jmp_valid = 1'b0;
  logic [31:0] jmp_target = 32'd0;
  logic [31:0] pc;
  logic        pc_valid;
  logic        in_delay_slot;
  logic        halted;
  logic        fault;
  logic [31:0] issue_count;

  pc_sequencer #(.RESET_PC(RST_PC), .PC_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
    .jmp_valid(jmp_valid), .jmp_target(jmp_target),
    .pc(pc), .pc_valid(pc_valid), .in_delay_slot(in_delay_slot),
    .halted(halted), .fault(fault), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        vld;
    logic        ids;
    logic        hlt;
    logic        flt;
    logic [31:0] cnt;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  // Behavioural model: architectural PC, an optional pending redirect, and
  // two sticky terminal flags.
  logic [31:0] m_pc, m_pend, m_cnt;
  bit          m_has_pend, m_halted, m_faulted;

  task automatic model_step(input logic r, s, bv, bt, input logic [31:0] btt,
                            input logic jv, input logic [31:0] jt);
    logic        want;
    logic [31:0] dest;
    if (r) begin
      m_pc = RST_PC; m_pend = 0; m_cnt = 0;
      m_has_pend = 0; m_halted = 0; m_faulted = 0;
    end else if (!m_halted && !m_faulted && !s) begin
      m_cnt = m_cnt + 1;
      want  = jv || (bv && bt);
      dest  = jv ? jt : btt;
      if (m_has_pend) begin
        m_has_pend = 0;
        if (want) m_faulted = 1;
        else      m_pc = m_pend;
      end else if (want) begin
        if ((dest % 4 == 0) && dest >= RST_PC && dest <= LIMIT) begin
          m_pend = dest; m_has_pend = 1; m_pc = m_pc + 4;
        end else begin
          m_faulted = 1;
        end
      end else begin
        m_pc = m_pc + 4;
      end
      if (!m_faulted && m_pc == LIMIT) begin
        m_halted = 1; m_has_pend = 0;
      end
    end
  endtask

  task automatic step(input logic r, s, bv, bt, input logic [31:0] btt,
                      input logic jv, input logic [31:0] jt);
    exp_t e;
    @(negedge clk);
    rst = r; stall = s; br_valid = bv; br_taken = bt; br_target = btt;
    jmp_valid = jv; jmp_target = jt;
    model_step(r, s, bv, bt, btt, jv, jt);
    e.pc  = m_pc;
    e.vld = !(m_halted || m_faulted);
    e.ids = m_has_pend;
    e.hlt = m_halted;
    e.flt = m_faulted;
    e.cnt = m_cnt;
    sbq.push_back(e);
  endtask

  task automatic idle();                step(0, 0, 0, 0, 0, 0, 0); endtask
  task automatic do_reset();            step(1, 0, 0, 0, 0, 0, 0); endtask
  task automatic jmp(input logic [31:0] t); step(0, 0, 0, 0, 0, 1, t); endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: the DUT presents a new output set after every clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("pc",            pc,                    e.pc);
        chk("pc_valid",      {31'd0, pc_valid},     {31'd0, e.vld});
        chk("in_delay_slot", {31'd0, in_delay_slot}, {31'd0, e.ids});
        chk("halted",        {31'd0, halted},       {31'd0, e.hlt});
        chk("fault",         {31'd0, fault},        {31'd0, e.flt});
        chk("issue_count",   issue_count,           e.cnt);
      end
    end
  end

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 9))
      0:       return RST_PC + 4 * $urandom_range(0, 32'hFFF) + $urandom_range(1, 3);
      1:       return RST_PC - 4 * $urandom_range(1, 64);
      2:       return LIMIT + 4 * $urandom_range(1, 64);
      3:       return LIMIT;
      default: return RST_PC + 4 * $urandom_range(0, 32'hFFF);
    endcase
  endfunction

  initial begin
    int guard;
    do_reset(); do_reset();

    // Free run, then a jump with its delay slot.
    repeat (2) idle();
    jmp(32'h3100);
    repeat (3) idle();

    // Stalled branch, then released.
    do_reset();
    repeat (2) step(0, 1, 1, 1, 32'h3040, 0, 0);
    step(0, 0, 1, 1, 32'h3040, 0, 0);
    repeat (2) idle();
    step(0, 0, 1, 0, 32'h3200, 0, 0);   // not taken: sequential

    // Faults: misaligned, above limit, redirect in delay slot.
    do_reset(); repeat (4) idle(); jmp(32'h3002); repeat (2) idle();
    do_reset(); jmp(32'h7004); repeat (2) idle();
    do_reset(); jmp(32'h3100); step(0, 0, 1, 1, 32'h3200, 0, 0); repeat (2) idle();
    do_reset(); step(0, 0, 0, 0, 0, 1, 32'h2FFC); idle();

    // Sequential run to the limit, then hold with random inputs.
    do_reset();
    guard = 0;
    while (m_pc != 32'h6FFC && guard < 5000) begin idle(); guard++; end
    idle();
    repeat (10) step(0, 1'($urandom), 1'($urandom), 1'($urandom), pick_target(),
                     1'($urandom), pick_target());

    // Jump straight to the limit halts after the delay slot.
    do_reset(); idle(); jmp(LIMIT); repeat (3) idle();

    // Reset while in the delay slot drops the pending target.
    do_reset(); jmp(32'h3200); do_reset(); repeat (3) idle();

    // Random traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic r, s, bv, bt, jv;
      r  = ($urandom_range(0, 99) < 2) ||
           ((m_halted || m_faulted) && $urandom_range(0, 3) == 0);
      s  = ($urandom_range(0, 3) == 0);
      jv = ($urandom_range(0, 99) < 12);
      bv = ($urandom_range(0, 99) < 30);
      bt = 1'($urandom);
      step(r, s, bv, bt, pick_target(), jv, pick_target());
    end

    repeat (2) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
